// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display bank: glyph codes,
// display-mode encodings and the all-segments-off pattern.
package seg7_pkg;

  // Non-hex glyph codes (0-15 are the hex digits themselves)
  localparam logic [4:0] GLYPH_H     = 5'd20;
  localparam logic [4:0] GLYPH_I     = 5'd21;
  localparam logic [4:0] GLYPH_L     = 5'd22;
  localparam logic [4:0] GLYPH_O     = 5'd23;
  localparam logic [4:0] GLYPH_MINUS = 5'd30;
  localparam logic [4:0] GLYPH_BLANK = 5'd31;

  // Display modes; the fourth encoding is reserved and shows static content
  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_SCROLL = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_t;

  // Active-low segments, bit 6 = a ... bit 0 = g; all ones is dark
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// Combinational glyph-code to active-low segment pattern (a..g = bit 6..0).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [4:0] i_code,
  output logic [6:0] o_seg
);

  // Fixed glyph table; anything not listed stays dark
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      5'd0:        o_seg = 7'b0000001;
      5'd1:        o_seg = 7'b1001111;
      5'd2:        o_seg = 7'b0010010;
      5'd3:        o_seg = 7'b0000110;
      5'd4:        o_seg = 7'b1001100;
      5'd5:        o_seg = 7'b0100100;
      5'd6:        o_seg = 7'b0100000;
      5'd7:        o_seg = 7'b0001111;
      5'd8:        o_seg = 7'b0000000;
      5'd9:        o_seg = 7'b0000100;
      5'd10:       o_seg = 7'b0001000;
      5'd11:       o_seg = 7'b1100000;
      5'd12:       o_seg = 7'b0110001;
      5'd13:       o_seg = 7'b1000010;
      5'd14:       o_seg = 7'b0110000;
      5'd15:       o_seg = 7'b0111000;
      GLYPH_H:     o_seg = 7'b1001000;
      GLYPH_I:     o_seg = 7'b1001111;
      GLYPH_L:     o_seg = 7'b1110001;
      GLYPH_O:     o_seg = 7'b0000001;
      GLYPH_MINUS: o_seg = 7'b1111110;
      default:     o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_bank.sv
// Multi-digit seven-segment controller: strobe-loaded display buffer,
// per-digit blinking and circular left scrolling, registered segment outputs.
module seg7_bank
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25_000_000,
  parameter int SCROLL_DIV = 50_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [5*NUM_DIGITS-1:0] codes,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic [1:0]              mode,
  output logic [7*NUM_DIGITS-1:0] led,
  output logic                    blink_phase
);

  localparam int BW = $clog2(BLINK_DIV);
  localparam int SW = $clog2(SCROLL_DIV);
  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);
  localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_DIV - 1);

  logic [NUM_DIGITS-1:0][4:0] r_disp;
  logic [NUM_DIGITS-1:0][4:0] w_disp_rot;
  logic [NUM_DIGITS-1:0][6:0] w_seg;
  logic [NUM_DIGITS-1:0][6:0] w_led_next;
  logic [NUM_DIGITS-1:0][6:0] r_led;
  logic [BW-1:0]              r_blink_cnt;
  logic [SW-1:0]              r_scroll_cnt;
  logic                       r_blink_phase;
  logic                       w_scroll_wrap;

  // The scroll counter only advances in scroll mode, so a wrap implies it
  assign w_scroll_wrap = (mode == MODE_SCROLL) && (r_scroll_cnt == SCROLL_LAST);

  // Blink divider runs in every mode; load restarts it with digits visible
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (load) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b1;
    end else if (r_blink_cnt == BLINK_LAST) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + BW'(1);
    end
  end

  // Scroll divider advances only in scroll mode and holds its count otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scroll_cnt <= '0;
    end else if (load) begin
      r_scroll_cnt <= '0;
    end else if (mode == MODE_SCROLL) begin
      if (r_scroll_cnt == SCROLL_LAST) begin
        r_scroll_cnt <= '0;
      end else begin
        r_scroll_cnt <= r_scroll_cnt + SW'(1);
      end
    end
  end

  // Display buffer: load has priority over a coincident rotation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp <= {NUM_DIGITS{GLYPH_BLANK}};
    end else if (load) begin
      r_disp <= codes;
    end else if (w_scroll_wrap) begin
      r_disp <= w_disp_rot;
    end
  end

  // Per-digit rotation source, decode and blink blanking
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_wrap
        assign w_disp_rot[gi] = r_disp[NUM_DIGITS-1];
      end else begin : g_shift
        assign w_disp_rot[gi] = r_disp[gi-1];
      end

      seg7_decode u_decode (
        .i_code (r_disp[gi]),
        .o_seg  (w_seg[gi])
      );

      assign w_led_next[gi] = ((mode == MODE_BLINK) && blink_mask[gi] && !r_blink_phase)
                              ? SEG_BLANK : w_seg[gi];
    end
  endgenerate

  // Registered segment outputs so the pins never see decode glitches
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      r_led <= w_led_next;
    end
  end

  assign led         = r_led;
  assign blink_phase = r_blink_phase;

endmodule

// File: tb/tb_seg7_bank.sv
// Directed bench for seg7_bank with NUM_DIGITS=4, BLINK_DIV=4, SCROLL_DIV=3.
module tb_seg7_bank;

  logic        clk;
  logic        reset;
  logic        load;
  logic [19:0] codes;
  logic [3:0]  blink_mask;
  logic [1:0]  mode;
  logic [27:0] led;
  logic        blink_phase;

  int n_tests;
  int n_fail;

  // Hand-written segment patterns (a..g, active low)
  localparam logic [6:0] P1 = 7'b1001111;
  localparam logic [6:0] P2 = 7'b0010010;
  localparam logic [6:0] P3 = 7'b0000110;
  localparam logic [6:0] P4 = 7'b1001100;
  localparam logic [6:0] PH = 7'b1001000;
  localparam logic [6:0] PI = 7'b1001111;
  localparam logic [6:0] PL = 7'b1110001;
  localparam logic [6:0] PO = 7'b0000001;
  localparam logic [6:0] PX = 7'h7F;

  logic [6:0] exp_tab [32];

  seg7_bank #(
    .NUM_DIGITS (4),
    .BLINK_DIV  (4),
    .SCROLL_DIV (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .codes       (codes),
    .blink_mask  (blink_mask),
    .mode        (mode),
    .led         (led),
    .blink_phase (blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [27:0] got, input logic [27:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] word(input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic logic [19:0] cw(input int c3, input int c2, input int c1, input int c0);
    return {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
  endfunction

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_tab[0]  = 7'b0000001; exp_tab[1]  = 7'b1001111;
    exp_tab[2]  = 7'b0010010; exp_tab[3]  = 7'b0000110;
    exp_tab[4]  = 7'b1001100; exp_tab[5]  = 7'b0100100;
    exp_tab[6]  = 7'b0100000; exp_tab[7]  = 7'b0001111;
    exp_tab[8]  = 7'b0000000; exp_tab[9]  = 7'b0000100;
    exp_tab[10] = 7'b0001000; exp_tab[11] = 7'b1100000;
    exp_tab[12] = 7'b0110001; exp_tab[13] = 7'b1000010;
    exp_tab[14] = 7'b0110000; exp_tab[15] = 7'b0111000;
    for (int i = 16; i < 32; i++) exp_tab[i] = 7'h7F;
    exp_tab[20] = 7'b1001000; exp_tab[21] = 7'b1001111;
    exp_tab[22] = 7'b1110001; exp_tab[23] = 7'b0000001;
    exp_tab[30] = 7'b1111110;

    reset      = 1'b0;
    load       = 1'b0;
    codes      = '0;
    blink_mask = '0;
    mode       = 2'd0;
    #3 reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    tick;
    chk("reset_led", led, 28'hFFFFFFF);
    chk("reset_phase", {27'd0, blink_phase}, 28'd1);

    // Static load: H I 0 blank
    codes = cw(20, 21, 0, 31);
    load  = 1'b1;
    tick;
    load  = 1'b0;
    chk("load_latency_old", led, 28'hFFFFFFF);
    tick;
    chk("load_static", led, word(7'b1001000, 7'b1001111, 7'b0000001, 7'b1111111));

    // Sweep every code into digit 0
    for (int c = 0; c < 32; c++) begin
      codes = cw(31, 31, 31, c);
      load  = 1'b1;
      tick;
      load  = 1'b0;
      tick;
      chk($sformatf("glyph_%0d", c), led, word(PX, PX, PX, exp_tab[c]));
    end

    // Blink: only digit 1 (code 3) blinks, 4 cycles visible / 4 blank
    mode       = 2'd1;
    blink_mask = 4'b0010;
    codes      = cw(1, 2, 3, 4);
    load       = 1'b1;
    tick;
    load       = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick;
      chk($sformatf("blink_led_k%0d", k), led,
          word(P1, P2, (((k - 1) / 4) % 2 == 0) ? P3 : PX, P4));
      chk($sformatf("blink_phase_k%0d", k), {27'd0, blink_phase},
          ((k / 4) % 2 == 0) ? 28'd1 : 28'd0);
    end

    // Mask ignored outside blink mode
    mode = 2'd0;
    tick;
    tick;
    tick;
    tick;
    tick;
    chk("mask_ignored_static", led, word(P1, P2, P3, P4));

    // Scroll: step every 3 cycles of scroll mode
    mode       = 2'd2;
    blink_mask = 4'b0000;
    codes      = cw(1, 2, 3, 4);
    load       = 1'b1;
    tick;               // edge t
    load       = 1'b0;
    tick; chk("scroll_k1", led, word(P1, P2, P3, P4));
    tick;
    tick; chk("scroll_k3", led, word(P1, P2, P3, P4));
    tick; chk("scroll_k4", led, word(P2, P3, P4, P1));
    tick; tick;
    tick; chk("scroll_k7", led, word(P3, P4, P1, P2));
    tick; tick;
    tick; chk("scroll_k10", led, word(P4, P1, P2, P3));
    tick; tick;
    tick; chk("scroll_k13", led, word(P1, P2, P3, P4));
    tick;               // edge t+14, next wrap would be at t+15

    // Load coincident with a scroll wrap
    codes = cw(20, 21, 22, 23);
    load  = 1'b1;
    tick;               // edge t'
    load  = 1'b0;
    tick; chk("wrapload_k1", led, word(PH, PI, PL, PO));
    tick;
    tick; chk("wrapload_k3", led, word(PH, PI, PL, PO));
    tick; chk("wrapload_k4", led, word(PI, PL, PO, PH));

    // Static mode holds the scroll count (currently 1)
    mode = 2'd0;
    for (int k = 0; k < 10; k++) tick;
    chk("static_hold", led, word(PI, PL, PO, PH));
    mode = 2'd2;
    tick;               // count 1 -> 2
    tick;               // wrap, rotate
    chk("resume_before", led, word(PI, PL, PO, PH));
    tick;
    chk("resume_after", led, word(PL, PO, PH, PI));

    // Asynchronous reset between edges
    #2 reset = 1'b1;
    #1;
    chk("async_reset_led", led, 28'hFFFFFFF);
    chk("async_reset_phase", {27'd0, blink_phase}, 28'd1);
    tick;
    reset = 1'b0;
    mode  = 2'd0;
    tick;
    chk("post_reset_led", led, 28'hFFFFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
